// File: rtl/pipe_ctrl_unit.sv
// Decode, hazard detection and RUN/DRAIN/HALT control for the 5-stage core.
// Optional perf counters are built when CTRL_PERF_CNT_EN is defined.
module pipe_ctrl_unit #(
    parameter int WORD         = 32,
    parameter int ALU_OP_W     = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic [4:0]          rs_addr,
    input  logic [4:0]          rt_addr,
    input  logic [4:0]          id_dest,
    input  logic [WORD-1:0]     reg_rs_d,
    input  logic [WORD-1:0]     reg_rt_d,
    output logic                stall,
    output logic                flush,
    output logic                branch_taken,
    output logic                jump_taken,
    output logic                ex_is_immd,
    output logic                ex_only_shamt,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_mem_r,
    output logic                ex_mem_w,
    output logic                ex_wb_en,
    output logic                mem_mem_r,
    output logic                mem_mem_w,
    output logic                mem_wb_en,
    output logic                draining,
    output logic                halted,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADIU = 6'h09;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_TERM = 6'h3F;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JAL   = 6'h08;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam logic [ALU_OP_W-1:0] A_NOP  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] A_ADD  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] A_ADDU = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] A_SUB  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] A_SUBU = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] A_AND  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] A_OR   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] A_XOR  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] A_NOR  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] A_LE   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] A_SHL  = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] A_SHR  = ALU_OP_W'(11);
    localparam logic [ALU_OP_W-1:0] A_SHRA = ALU_OP_W'(12);

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef struct packed {
        logic                is_immd;
        logic                only_shamt;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_r;
        logic                mem_w;
        logic                wb_en;
    } ctrl_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    ctrl_t            dec;
    ctrl_t            ex_q;
    logic [4:0]       ex_dest_q;
    logic [2:0]       mem_q;
    logic             jump_dec;
    logic             is_br;
    logic             br_dec;
    logic             uses_rt;
    logic             term;
    logic             hz_load;
    logic             hz_br;
    state_t           state_q;
    state_t           state_d;
    logic [DC_W-1:0]  cnt_q;
    logic [DC_W-1:0]  cnt_d;

    always_comb begin
        dec      = '0;
        jump_dec = 1'b0;
        case (op)
            OP_SW:   dec = '{1'b1, 1'b0, A_ADD, 1'b0, 1'b1, 1'b0};
            OP_LW:   dec = '{1'b1, 1'b0, A_ADD, 1'b1, 1'b0, 1'b1};
            OP_ADDI,
            OP_ADIU: dec = '{1'b1, 1'b0, A_ADD, 1'b0, 1'b0, 1'b1};
            OP_ANDI: dec = '{1'b1, 1'b0, A_AND, 1'b0, 1'b0, 1'b1};
            OP_ORI:  dec = '{1'b1, 1'b0, A_OR,  1'b0, 1'b0, 1'b1};
            OP_XORI: dec = '{1'b1, 1'b0, A_XOR, 1'b0, 1'b0, 1'b1};
            OP_J:    jump_dec = 1'b1;
            OP_R: begin
                case (funct)
                    F_ADD:  dec = '{1'b0, 1'b0, A_ADD,  1'b0, 1'b0, 1'b1};
                    F_ADDU: dec = '{1'b0, 1'b0, A_ADDU, 1'b0, 1'b0, 1'b1};
                    F_SUB:  dec = '{1'b0, 1'b0, A_SUB,  1'b0, 1'b0, 1'b1};
                    F_SUBU: dec = '{1'b0, 1'b0, A_SUBU, 1'b0, 1'b0, 1'b1};
                    F_AND:  dec = '{1'b0, 1'b0, A_AND,  1'b0, 1'b0, 1'b1};
                    F_OR:   dec = '{1'b0, 1'b0, A_OR,   1'b0, 1'b0, 1'b1};
                    F_XOR:  dec = '{1'b0, 1'b0, A_XOR,  1'b0, 1'b0, 1'b1};
                    F_NOR:  dec = '{1'b0, 1'b0, A_NOR,  1'b0, 1'b0, 1'b1};
                    F_SLT:  dec = '{1'b0, 1'b0, A_LE,   1'b0, 1'b0, 1'b1};
                    F_SLL:  dec = '{1'b0, 1'b1, A_SHL,  1'b0, 1'b0, 1'b1};
                    F_SRL:  dec = '{1'b0, 1'b1, A_SHR,  1'b0, 1'b0, 1'b1};
                    F_SRA:  dec = '{1'b0, 1'b1, A_SHRA, 1'b0, 1'b0, 1'b1};
                    F_SLLV: dec = '{1'b0, 1'b0, A_SHL,  1'b0, 1'b0, 1'b1};
                    F_SRLV: dec = '{1'b0, 1'b0, A_SHR,  1'b0, 1'b0, 1'b1};
                    F_SRAV: dec = '{1'b0, 1'b0, A_SHRA, 1'b0, 1'b0, 1'b1};
                    F_JAL:  jump_dec = 1'b1;
                    default: dec = '0;
                endcase
            end
            default: dec = '0;
        endcase
    end

    assign is_br   = (op == OP_BEQ) | (op == OP_BNE);
    assign br_dec  = ((op == OP_BEQ) & (reg_rs_d == reg_rt_d))
                   | ((op == OP_BNE) & (reg_rs_d != reg_rt_d));
    assign uses_rt = (op == OP_R) | is_br | (op == OP_SW);
    assign term    = (op == OP_TERM) & (funct == OP_TERM);

    assign hz_load = ex_q.mem_r & (ex_dest_q != 5'd0)
                   & ((ex_dest_q == rs_addr)
                   | ((ex_dest_q == rt_addr) & uses_rt));
    assign hz_br   = is_br & ex_q.wb_en & (ex_dest_q != 5'd0)
                   & ((ex_dest_q == rs_addr) | (ex_dest_q == rt_addr));

    // Gating with rst keeps the ID-stage redirects quiet while held in reset.
    assign stall        = hz_load | hz_br | (state_q != RUN);
    assign branch_taken = br_dec & ~stall & ~rst;
    assign jump_taken   = jump_dec & ~stall & ~rst;
    assign flush        = branch_taken | jump_taken;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (term && !hz_load && !hz_br) begin
                    state_d = DRAIN;
                    cnt_d   = DC_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = HALT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            ex_q      <= '0;
            ex_dest_q <= '0;
            mem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_q      <= (stall || flush) ? '0 : dec;
            ex_dest_q <= id_dest;
            mem_q     <= {ex_q.mem_r, ex_q.mem_w, ex_q.wb_en};
        end
    end

    assign ex_is_immd    = ex_q.is_immd;
    assign ex_only_shamt = ex_q.only_shamt;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_mem_r      = ex_q.mem_r;
    assign ex_mem_w      = ex_q.mem_w;
    assign ex_wb_en      = ex_q.wb_en;
    assign mem_mem_r     = mem_q[2];
    assign mem_mem_w     = mem_q[1];
    assign mem_wb_en     = mem_q[0];
    assign draining      = (state_q == DRAIN);
    assign halted        = (state_q == HALT);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters, frozen once the core has halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != HALT) begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed cycles push expected
// outputs, a negedge monitor pops and compares them.
module tb_pipe_ctrl_unit;

    localparam logic [3:0] A_ADD  = 4'd1;
    localparam logic [3:0] A_XOR  = 4'd7;
    localparam logic [3:0] A_LE   = 4'd9;
    localparam logic [3:0] A_SHL  = 4'd10;
    localparam logic [3:0] A_SHRA = 4'd12;

    // ex vector: {is_immd, only_shamt, alu_op, mem_r, mem_w, wb_en}
    localparam logic [8:0] X0    = 9'd0;
    localparam logic [8:0] X_LW  = {2'b10, A_ADD, 3'b101};
    localparam logic [8:0] X_SW  = {2'b10, A_ADD, 3'b010};
    localparam logic [8:0] X_ADI = {2'b10, A_ADD, 3'b001};
    localparam logic [8:0] X_ADD = {2'b00, A_ADD, 3'b001};
    localparam logic [8:0] X_SRA = {2'b01, A_SHRA, 3'b001};
    localparam logic [8:0] X_SLV = {2'b00, A_SHL, 3'b001};
    localparam logic [8:0] X_XRI = {2'b10, A_XOR, 3'b001};
    localparam logic [8:0] X_SLT = {2'b00, A_LE, 3'b001};

    // mem vector: {mem_r, mem_w, wb_en}
    localparam logic [2:0] M0  = 3'b000;
    localparam logic [2:0] MLW = 3'b101;
    localparam logic [2:0] MSW = 3'b010;
    localparam logic [2:0] MWB = 3'b001;

    // comb vector: {stall, flush, branch_taken, jump_taken}
    localparam logic [3:0] C0  = 4'b0000;
    localparam logic [3:0] CST = 4'b1000;
    localparam logic [3:0] CBR = 4'b0110;
    localparam logic [3:0] CJ  = 4'b0101;

    localparam logic [5:0] NOP = 6'h3E;
    localparam logic [5:0] RT  = 6'h00;
    localparam logic [5:0] J   = 6'h02;
    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] BNE = 6'h05;
    localparam logic [5:0] ADI = 6'h08;
    localparam logic [5:0] XRI = 6'h0E;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] TRM = 6'h3F;

`ifdef CTRL_PERF_CNT_EN
    localparam logic [31:0] EXP_SC = 32'd2;
    localparam logic [31:0] EXP_FC = 32'd1;
`else
    localparam logic [31:0] EXP_SC = 32'd0;
    localparam logic [31:0] EXP_FC = 32'd0;
`endif

    typedef struct {
        logic [3:0] comb;
        logic [8:0] ex;
        logic [2:0] mem;
        logic [1:0] fsm;
        bit         chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = NOP;
    logic [5:0]  funct = 6'h0;
    logic [4:0]  rs_addr = 5'd0;
    logic [4:0]  rt_addr = 5'd0;
    logic [4:0]  id_dest = 5'd0;
    logic [31:0] reg_rs_d = 32'd0;
    logic [31:0] reg_rt_d = 32'd0;
    logic        stall, flush, branch_taken, jump_taken;
    logic        ex_is_immd, ex_only_shamt, ex_mem_r, ex_mem_w, ex_wb_en;
    logic [3:0]  ex_alu_op;
    logic        mem_mem_r, mem_mem_w, mem_wb_en;
    logic        draining, halted;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .id_dest(id_dest),
        .reg_rs_d(reg_rs_d), .reg_rt_d(reg_rt_d),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .jump_taken(jump_taken),
        .ex_is_immd(ex_is_immd), .ex_only_shamt(ex_only_shamt),
        .ex_alu_op(ex_alu_op), .ex_mem_r(ex_mem_r),
        .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en),
        .mem_mem_r(mem_mem_r), .mem_mem_w(mem_mem_w),
        .mem_wb_en(mem_wb_en), .draining(draining), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Monitor: every negedge with a pending expectation is one observation.
    initial begin
        int idx;
        exp_t e;
        idx = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("comb", idx, 32'({stall, flush, branch_taken, jump_taken}),
                    32'(e.comb));
                cmp("ex", idx, 32'({ex_is_immd, ex_only_shamt, ex_alu_op,
                    ex_mem_r, ex_mem_w, ex_wb_en}), 32'(e.ex));
                cmp("mem", idx, 32'({mem_mem_r, mem_mem_w, mem_wb_en}),
                    32'(e.mem));
                cmp("fsm", idx, 32'({draining, halted}), 32'(e.fsm));
                if (e.chk) begin
                    cmp("stall_cnt", idx, stall_cnt, EXP_SC);
                    cmp("flush_cnt", idx, flush_cnt, EXP_FC);
                end
                idx++;
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] d, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] ec,
                        input logic [8:0] ex, input logic [2:0] em,
                        input logic [1:0] ef, input bit chk = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; op = o; funct = f;
        rs_addr = rs; rt_addr = rt; id_dest = d;
        reg_rs_d = a; reg_rt_d = b;
        e.comb = ec; e.ex = ex; e.mem = em; e.fsm = ef; e.chk = chk;
        q.push_back(e);
        step_no++;
    endtask

    initial begin
        int wait_cyc;
        // reset with a would-be-taken BEQ on the inputs
        step(1, BEQ, 0, 1, 2, 0, 32'h1234, 32'h1234, C0, X0, M0, 2'b00);
        step(0, NOP, 0, 0, 0, 0, 0, 0, C0, X0, M0, 2'b00);
        // load-use on rs
        step(0, LW, 0, 1, 5, 5, 0, 0, C0, X0, M0, 2'b00);
        step(0, RT, 6'h20, 5, 6, 8, 0, 0, CST, X_LW, M0, 2'b00);
        step(0, RT, 6'h20, 5, 6, 8, 0, 0, C0, X0, MLW, 2'b00);
        // taken BEQ
        step(0, BEQ, 0, 1, 2, 0, 32'h1234, 32'h1234, CBR, X_ADD, M0, 2'b00);
        // branch-operand hazard, then taken BNE
        step(0, ADI, 0, 1, 7, 7, 0, 0, C0, X0, MWB, 2'b00);
        step(0, BNE, 0, 7, 3, 0, 32'd1, 32'd2, CST, X_ADI, M0, 2'b00);
        step(0, BNE, 0, 7, 3, 0, 32'd1, 32'd2, CBR, X0, MWB, 2'b00);
        step(0, J, 0, 0, 0, 0, 0, 0, CJ, X0, M0, 2'b00);
        // decode coverage
        step(0, SW, 0, 1, 4, 0, 0, 0, C0, X0, M0, 2'b00);
        step(0, RT, 6'h03, 0, 4, 9, 0, 0, C0, X_SW, M0, 2'b00);
        step(0, RT, 6'h04, 1, 4, 10, 0, 0, C0, X_SRA, MSW, 2'b00);
        step(0, XRI, 0, 1, 11, 11, 0, 0, C0, X_SLV, MWB, 2'b00);
        step(0, RT, 6'h2A, 1, 2, 12, 0, 0, C0, X_XRI, MWB, 2'b00);
        // load-use on rt (SW uses rt)
        step(0, LW, 0, 1, 3, 3, 0, 0, C0, X_SLT, MWB, 2'b00);
        step(0, SW, 0, 2, 3, 0, 0, 0, CST, X_LW, MWB, 2'b00);
        step(0, SW, 0, 2, 3, 0, 0, 0, C0, X0, MLW, 2'b00);
        // load into r0 never stalls
        step(0, LW, 0, 1, 0, 0, 0, 0, C0, X_SW, M0, 2'b00);
        step(0, RT, 6'h20, 0, 0, 4, 0, 0, C0, X_LW, MSW, 2'b00);
        // ADDI does not use rt, so rt match is not a hazard
        step(0, LW, 0, 1, 6, 6, 0, 0, C0, X_ADD, MLW, 2'b00);
        step(0, ADI, 0, 2, 6, 7, 0, 0, C0, X_LW, MWB, 2'b00);
        // terminate held off by a hazard, then drain and halt
        step(0, LW, 0, 1, 6, 6, 0, 0, C0, X_ADI, MLW, 2'b00);
        step(0, TRM, TRM, 6, 0, 0, 0, 0, CST, X_LW, MWB, 2'b00);
        step(0, TRM, TRM, 6, 0, 0, 0, 0, C0, X0, MLW, 2'b00);
        step(0, NOP, 0, 0, 0, 0, 0, 0, CST, X0, M0, 2'b10);
        step(0, BEQ, 0, 1, 2, 0, 32'h55, 32'h55, CST, X0, M0, 2'b10);
        step(0, NOP, 0, 0, 0, 0, 0, 0, CST, X0, M0, 2'b10);
        step(0, NOP, 0, 0, 0, 0, 0, 0, CST, X0, M0, 2'b01);
        step(0, J, 0, 0, 0, 0, 0, 0, CST, X0, M0, 2'b01);
        // reset clears HALT; reset mid-drain returns to RUN
        step(1, NOP, 0, 0, 0, 0, 0, 0, C0, X0, M0, 2'b00);
        step(0, TRM, TRM, 0, 0, 0, 0, 0, C0, X0, M0, 2'b00);
        step(0, NOP, 0, 0, 0, 0, 0, 0, CST, X0, M0, 2'b10);
        step(1, NOP, 0, 0, 0, 0, 0, 0, C0, X0, M0, 2'b00);
        step(0, NOP, 0, 0, 0, 0, 0, 0, C0, X0, M0, 2'b00);
        // two load-use stalls and one jump for the counters
        step(0, LW, 0, 1, 5, 5, 0, 0, C0, X0, M0, 2'b00);
        step(0, RT, 6'h20, 5, 6, 8, 0, 0, CST, X_LW, M0, 2'b00);
        step(0, RT, 6'h20, 5, 6, 8, 0, 0, C0, X0, MLW, 2'b00);
        step(0, LW, 0, 1, 5, 5, 0, 0, C0, X_ADD, M0, 2'b00);
        step(0, RT, 6'h20, 5, 6, 8, 0, 0, CST, X_LW, MWB, 2'b00);
        step(0, RT, 6'h20, 5, 6, 8, 0, 0, C0, X0, MLW, 2'b00);
        step(0, J, 0, 0, 0, 0, 0, 0, CJ, X_ADD, M0, 2'b00);
        step(0, NOP, 0, 0, 0, 0, 0, 0, C0, X0, MWB, 2'b00, 1'b1);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain_queue: %0d left want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
